// File: rtl/int_ctrl_pkg.sv
// Shared types and sizes for the interrupt controller: FSM states, source count,
// code width, level-stack depth and the priority winner helper.
package int_pkg;

  localparam int NUM_SRC     = 3;
  localparam int CODE_W      = 2;
  localparam int STACK_DEPTH = 3;
  localparam int SP_W        = 2;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    GAP    = 2'd2
  } state_t;

  typedef logic [CODE_W-1:0]  code_t;
  typedef logic [NUM_SRC-1:0] src_t;

  // Highest eligible index wins; the code is index+1 so that 0 can mean "none".
  function automatic code_t pick_winner(input src_t elig);
    code_t c;
    c = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (elig[i]) c = code_t'(i + 1);
    end
    return c;
  endfunction

endpackage

// File: rtl/int_ctrl_if.sv
// Bundle between the board/CP0 side (master) and the interrupt controller (slave).
interface int_ctrl_if;
  import int_pkg::*;

  src_t        in_IRQ;
  logic        in_IE;
  logic [3:0]  in_INM;
  logic        in_eret;
  logic        in_stall;
  code_t       out_code;
  logic        out_BK;
  logic        out_NIE;
  logic [31:0] out_vector;
  src_t        out_pending;
  code_t       out_level;

  modport master (
    output in_IRQ, in_IE, in_INM, in_eret, in_stall,
    input  out_code, out_BK, out_NIE, out_vector, out_pending, out_level
  );

  modport slave (
    input  in_IRQ, in_IE, in_INM, in_eret, in_stall,
    output out_code, out_BK, out_NIE, out_vector, out_pending, out_level
  );

endinterface

// File: rtl/int_ctrl_irq_edge_sync.sv
// One interrupt source: SYNC_STAGES-deep synchroniser followed by a rising-edge
// detector; rise is a single-cycle pulse, combinational from the last sync flop.
module irq_edge_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic in_CLK,
  input  logic in_RST,
  input  logic irq_raw,
  output logic rise
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], irq_raw};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: pending latches, mask/enable, nested priority arbitration
// with a level stack, and a one-cycle break pulse plus vector toward CP0/PC select.
module int_ctrl
  import int_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [31:0] VEC_BASE    = 32'h0000_0200,
  parameter logic [31:0] VEC_STRIDE  = 32'h0000_0010
) (
  input  logic     in_CLK,
  input  logic     in_RST,
  int_ctrl_if.slave bus
);

  src_t        rise;
  src_t        pend_q;
  src_t        pend_d;
  src_t        elig;
  src_t        clr_mask;
  code_t       win;
  logic        take;
  state_t      state_q;
  state_t      state_d;
  code_t       cur_lvl_q;
  code_t       stack_q [STACK_DEPTH];
  logic [SP_W-1:0] sp_q;
  code_t       code_q;
  logic        bk_q;
  logic        nie_q;
  logic [31:0] vector_q;
  logic        unused_inm3;

  assign unused_inm3 = bus.in_INM[3];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .in_CLK (in_CLK),
      .in_RST (in_RST),
      .irq_raw(bus.in_IRQ[g]),
      .rise   (rise[g])
    );
  end

  assign elig = pend_q & ~bus.in_INM[NUM_SRC-1:0];
  assign win  = pick_winner(elig);

  // ERET in the same cycle blocks the take; the popped level is used next cycle.
  assign take = (state_q == IDLE) && bus.in_IE && !bus.in_stall && !bus.in_eret
                && (win > cur_lvl_q);

  always_comb begin
    state_d  = state_q;
    clr_mask = '0;
    case (state_q)
      IDLE:    if (take) state_d = ASSERT;
      ASSERT:  state_d = GAP;
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    for (int i = 0; i < NUM_SRC; i++) begin
      clr_mask[i] = take && (win == code_t'(i + 1));
    end
  end

  // A new edge wins over a clear landing in the same cycle.
  assign pend_d = (pend_q & ~clr_mask) | rise;

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      state_q <= IDLE;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
    end
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      cur_lvl_q <= '0;
      sp_q      <= '0;
      for (int i = 0; i < STACK_DEPTH; i++) stack_q[i] <= '0;
    end else if (take) begin
      stack_q[sp_q] <= cur_lvl_q;
      sp_q          <= sp_q + 1'b1;
      cur_lvl_q     <= win;
    end else if (bus.in_eret) begin
      if (sp_q != '0) begin
        cur_lvl_q <= stack_q[sp_q - 1'b1];
        sp_q      <= sp_q - 1'b1;
      end else begin
        cur_lvl_q <= '0;
      end
    end
  end

  // Outputs come straight from flops; ASSERT is only ever entered through a take.
  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      code_q   <= '0;
      bk_q     <= 1'b0;
      nie_q    <= 1'b1;
      vector_q <= '0;
    end else begin
      code_q <= take ? win : '0;
      bk_q   <= take;
      nie_q  <= !take;
      if (take) vector_q <= VEC_BASE + VEC_STRIDE * {{(32-CODE_W){1'b0}}, win};
    end
  end

  assign bus.out_code    = code_q;
  assign bus.out_BK      = bk_q;
  assign bus.out_NIE     = nie_q;
  assign bus.out_vector  = vector_q;
  assign bus.out_pending = pend_q;
  assign bus.out_level   = cur_lvl_q;

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: latency, masking, nesting, blocking, stall/IE/ERET
// interplay and asynchronous reset, all against hand-computed values.
module tb_int_ctrl;

  logic in_CLK = 1'b0;
  logic in_RST;
  int   total = 0;
  int   bad   = 0;

  int_ctrl_if bus();

  int_ctrl #(
    .SYNC_STAGES(2),
    .VEC_BASE   (32'h0000_0200),
    .VEC_STRIDE (32'h0000_0010)
  ) dut (
    .in_CLK(in_CLK),
    .in_RST(in_RST),
    .bus   (bus)
  );

  always #5 in_CLK = ~in_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge in_CLK);
    #1;
  endtask

  // Ticks until out_BK is seen high; n = ticks taken, -1 if the budget runs out.
  task automatic wait_bk(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (bus.out_BK === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic watch_bk(input int cycles, output int seen);
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      tick();
      if (bus.out_BK !== 1'b0) seen++;
    end
  endtask

  task automatic do_eret();
    bus.in_eret = 1'b1;
    tick();
    bus.in_eret = 1'b0;
  endtask

  task automatic test_reset();
    in_RST = 1'b1;
    tick();
    tick();
    total++; if (bus.out_code !== 2'd0) begin bad++; $display("FAIL reset_code got=%0d want=0", bus.out_code); end
    total++; if (bus.out_BK !== 1'b0) begin bad++; $display("FAIL reset_bk got=%0b want=0", bus.out_BK); end
    total++; if (bus.out_NIE !== 1'b1) begin bad++; $display("FAIL reset_nie got=%0b want=1", bus.out_NIE); end
    total++; if (bus.out_vector !== 32'h0) begin bad++; $display("FAIL reset_vector got=%0h want=0", bus.out_vector); end
    total++; if (bus.out_pending !== 3'b000) begin bad++; $display("FAIL reset_pending got=%0b want=000", bus.out_pending); end
    total++; if (bus.out_level !== 2'd0) begin bad++; $display("FAIL reset_level got=%0d want=0", bus.out_level); end
    in_RST = 1'b0;
    tick();
  endtask

  task automatic test_single();
    int n;
    bus.in_IE  = 1'b1;
    bus.in_INM = 4'b0000;
    bus.in_IRQ = 3'b001;
    wait_bk(8, n);
    total++; if (n !== 4) begin bad++; $display("FAIL single_latency got=%0d want=4", n); end
    total++; if (bus.out_code !== 2'd1) begin bad++; $display("FAIL single_code got=%0d want=1", bus.out_code); end
    total++; if (bus.out_vector !== 32'h210) begin bad++; $display("FAIL single_vector got=%0h want=210", bus.out_vector); end
    total++; if (bus.out_NIE !== 1'b0) begin bad++; $display("FAIL single_nie_assert got=%0b want=0", bus.out_NIE); end
    total++; if (bus.out_level !== 2'd1) begin bad++; $display("FAIL single_level got=%0d want=1", bus.out_level); end
    total++; if (bus.out_pending !== 3'b000) begin bad++; $display("FAIL single_pend_clr got=%0b want=000", bus.out_pending); end
    tick();
    total++; if (bus.out_code !== 2'd0) begin bad++; $display("FAIL single_gap_code got=%0d want=0", bus.out_code); end
    total++; if (bus.out_BK !== 1'b0) begin bad++; $display("FAIL single_gap_bk got=%0b want=0", bus.out_BK); end
    total++; if (bus.out_NIE !== 1'b1) begin bad++; $display("FAIL single_gap_nie got=%0b want=1", bus.out_NIE); end
    total++; if (bus.out_vector !== 32'h210) begin bad++; $display("FAIL single_vector_hold got=%0h want=210", bus.out_vector); end
    tick();
    tick();
    total++; if (bus.out_pending !== 3'b000) begin bad++; $display("FAIL single_level_high_no_repend got=%0b want=000", bus.out_pending); end
    bus.in_IRQ = 3'b000;
    do_eret();
    total++; if (bus.out_level !== 2'd0) begin bad++; $display("FAIL single_eret_level got=%0d want=0", bus.out_level); end
  endtask

  task automatic test_mask_defer();
    int n;
    int seen;
    bus.in_INM = 4'b0010;
    bus.in_IRQ = 3'b010;
    tick();
    bus.in_IRQ = 3'b000;
    watch_bk(6, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL mask_no_take got=%0d want=0", seen); end
    total++; if (bus.out_pending !== 3'b010) begin bad++; $display("FAIL mask_pending got=%0b want=010", bus.out_pending); end
    bus.in_INM = 4'b0000;
    wait_bk(4, n);
    total++; if (n !== 1) begin bad++; $display("FAIL unmask_latency got=%0d want=1", n); end
    total++; if (bus.out_code !== 2'd2) begin bad++; $display("FAIL unmask_code got=%0d want=2", bus.out_code); end
    total++; if (bus.out_vector !== 32'h220) begin bad++; $display("FAIL unmask_vector got=%0h want=220", bus.out_vector); end
    tick();
    tick();
    do_eret();
    total++; if (bus.out_level !== 2'd0) begin bad++; $display("FAIL unmask_eret_level got=%0d want=0", bus.out_level); end
  endtask

  task automatic test_priority();
    int n;
    bus.in_IRQ = 3'b101;
    wait_bk(8, n);
    bus.in_IRQ = 3'b000;
    total++; if (n !== 4) begin bad++; $display("FAIL prio_latency got=%0d want=4", n); end
    total++; if (bus.out_code !== 2'd3) begin bad++; $display("FAIL prio_code got=%0d want=3", bus.out_code); end
    total++; if (bus.out_pending !== 3'b001) begin bad++; $display("FAIL prio_pending got=%0b want=001", bus.out_pending); end
    tick();
    tick();
    tick();
    total++; if (bus.out_BK !== 1'b0) begin bad++; $display("FAIL prio_lower_blocked got=%0b want=0", bus.out_BK); end
    do_eret();
    total++; if (bus.out_level !== 2'd0) begin bad++; $display("FAIL prio_eret_level got=%0d want=0", bus.out_level); end
    total++; if (bus.out_BK !== 1'b0) begin bad++; $display("FAIL prio_eret_blocks got=%0b want=0", bus.out_BK); end
    wait_bk(4, n);
    total++; if (n !== 1) begin bad++; $display("FAIL prio_second_latency got=%0d want=1", n); end
    total++; if (bus.out_code !== 2'd1) begin bad++; $display("FAIL prio_second_code got=%0d want=1", bus.out_code); end
    tick();
    tick();
    bus.in_IRQ = 3'b010;
    wait_bk(8, n);
    bus.in_IRQ = 3'b000;
    total++; if (n !== 4) begin bad++; $display("FAIL nest_latency got=%0d want=4", n); end
    total++; if (bus.out_code !== 2'd2) begin bad++; $display("FAIL nest_code got=%0d want=2", bus.out_code); end
    total++; if (bus.out_level !== 2'd2) begin bad++; $display("FAIL nest_level got=%0d want=2", bus.out_level); end
    tick();
    tick();
    do_eret();
    total++; if (bus.out_level !== 2'd1) begin bad++; $display("FAIL nest_pop1 got=%0d want=1", bus.out_level); end
    do_eret();
    total++; if (bus.out_level !== 2'd0) begin bad++; $display("FAIL nest_pop2 got=%0d want=0", bus.out_level); end
  endtask

  task automatic test_blocked();
    int n;
    int seen;
    bus.in_IRQ = 3'b010;
    wait_bk(8, n);
    bus.in_IRQ = 3'b000;
    total++; if (bus.out_level !== 2'd2) begin bad++; $display("FAIL block_setup_level got=%0d want=2", bus.out_level); end
    tick();
    tick();
    bus.in_IRQ = 3'b011;
    tick();
    bus.in_IRQ = 3'b000;
    watch_bk(6, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL block_same_lower got=%0d want=0", seen); end
    total++; if (bus.out_pending !== 3'b011) begin bad++; $display("FAIL block_pending got=%0b want=011", bus.out_pending); end
    do_eret();
    wait_bk(4, n);
    total++; if (n !== 1) begin bad++; $display("FAIL block_release_latency got=%0d want=1", n); end
    total++; if (bus.out_code !== 2'd2) begin bad++; $display("FAIL block_release_code got=%0d want=2", bus.out_code); end
    total++; if (bus.out_pending !== 3'b001) begin bad++; $display("FAIL block_release_pending got=%0b want=001", bus.out_pending); end
    tick();
    tick();
    watch_bk(3, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL block_lower_again got=%0d want=0", seen); end
    do_eret();
    wait_bk(4, n);
    total++; if (bus.out_code !== 2'd1) begin bad++; $display("FAIL block_final_code got=%0d want=1", bus.out_code); end
    tick();
    tick();
    do_eret();
    total++; if (bus.out_level !== 2'd0) begin bad++; $display("FAIL block_final_level got=%0d want=0", bus.out_level); end
  endtask

  task automatic test_stall_ie_eret();
    int n;
    int seen;
    bus.in_stall = 1'b1;
    bus.in_IRQ   = 3'b001;
    tick();
    bus.in_IRQ = 3'b000;
    watch_bk(6, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL stall_no_take got=%0d want=0", seen); end
    total++; if (bus.out_pending !== 3'b001) begin bad++; $display("FAIL stall_pending got=%0b want=001", bus.out_pending); end
    bus.in_stall = 1'b0;
    wait_bk(4, n);
    total++; if (n !== 1) begin bad++; $display("FAIL stall_release got=%0d want=1", n); end
    total++; if (bus.out_NIE !== 1'b0) begin bad++; $display("FAIL stall_nie_assert got=%0b want=0", bus.out_NIE); end
    tick();
    do_eret();
    bus.in_IE  = 1'b0;
    bus.in_IRQ = 3'b100;
    tick();
    bus.in_IRQ = 3'b000;
    watch_bk(6, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL ie0_no_take got=%0d want=0", seen); end
    total++; if (bus.out_pending !== 3'b100) begin bad++; $display("FAIL ie0_pending got=%0b want=100", bus.out_pending); end
    total++; if (bus.out_NIE !== 1'b1) begin bad++; $display("FAIL idle_nie got=%0b want=1", bus.out_NIE); end
    bus.in_IE   = 1'b1;
    bus.in_eret = 1'b1;
    tick();
    bus.in_eret = 1'b0;
    total++; if (bus.out_BK !== 1'b0) begin bad++; $display("FAIL eret_collision_blocks got=%0b want=0", bus.out_BK); end
    tick();
    total++; if (bus.out_BK !== 1'b1) begin bad++; $display("FAIL eret_collision_next got=%0b want=1", bus.out_BK); end
    total++; if (bus.out_code !== 2'd3) begin bad++; $display("FAIL eret_collision_code got=%0d want=3", bus.out_code); end
    tick();
    tick();
    do_eret();
  endtask

  task automatic test_reset_mid();
    int n;
    int seen;
    bus.in_INM = 4'b0001;
    bus.in_IRQ = 3'b101;
    wait_bk(8, n);
    bus.in_IRQ = 3'b000;
    total++; if (bus.out_code !== 2'd3) begin bad++; $display("FAIL rmid_code got=%0d want=3", bus.out_code); end
    total++; if (bus.out_pending !== 3'b001) begin bad++; $display("FAIL rmid_masked_pending got=%0b want=001", bus.out_pending); end
    in_RST = 1'b1;
    #1;
    total++; if (bus.out_BK !== 1'b0) begin bad++; $display("FAIL rmid_bk got=%0b want=0", bus.out_BK); end
    total++; if (bus.out_code !== 2'd0) begin bad++; $display("FAIL rmid_code_drop got=%0d want=0", bus.out_code); end
    total++; if (bus.out_NIE !== 1'b1) begin bad++; $display("FAIL rmid_nie got=%0b want=1", bus.out_NIE); end
    total++; if (bus.out_vector !== 32'h0) begin bad++; $display("FAIL rmid_vector got=%0h want=0", bus.out_vector); end
    total++; if (bus.out_pending !== 3'b000) begin bad++; $display("FAIL rmid_pending got=%0b want=000", bus.out_pending); end
    total++; if (bus.out_level !== 2'd0) begin bad++; $display("FAIL rmid_level got=%0d want=0", bus.out_level); end
    tick();
    in_RST     = 1'b0;
    bus.in_INM = 4'b0000;
    watch_bk(6, seen);
    total++; if (seen !== 0) begin bad++; $display("FAIL rmid_request_lost got=%0d want=0", seen); end
  endtask

  initial begin
    in_RST       = 1'b1;
    bus.in_IRQ   = 3'b000;
    bus.in_IE    = 1'b0;
    bus.in_INM   = 4'b0000;
    bus.in_eret  = 1'b0;
    bus.in_stall = 1'b0;
    test_reset();
    test_single();
    test_mask_defer();
    test_priority();
    test_blocked();
    test_stall_ie_eret();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
